board_lock_clear: RTL and testbench

Downstream of `piece_decoder`: merges a locked `active_piece_grid_t` into the registered playfield, then scans and removes full rows. Owns the authoritative board state that the collision logic and display path read. Reports per-lock cleared-line count and keeps a running total. One lock operation is processed at a time, under a ready/valid handshake.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/grid_to_board_mask.sv | 44 ++++
 rtl/board_lock_clear.sv | 129 ++++++++++++
 tb/tb_board_lock_clear.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield types for the tetris datapath: board geometry, the locked-piece
// grid handed down by piece_decoder, and the lock/clear sequencer states.
package tetris_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;

   // bit [row][col], row 0 is the top of the well
   typedef logic [BOARD_H-1:0][BOARD_W-1:0] board_t;

   // piece[r][c] is the cell r rows below and c columns right of origin (x, y)
   typedef struct packed {
      logic [3:0][3:0] piece;
      logic [4:0]      x;
      logic [4:0]      y;
   } active_piece_grid_t;

   typedef enum logic [2:0] {
      IDLE,
      MERGE,
      SCAN,
      SHIFT,
      DONE
   } lock_state_t;

endpackage

// File: rtl/grid_to_board_mask.sv
// Projects a 4x4 piece grid onto the playfield as a board-sized bit mask and flags
// any set cell that falls outside the well (such cells are simply left out of the mask).
module grid_to_board_mask
   import tetris_pkg::*;
(
   input  active_piece_grid_t grid,
   output board_t             mask,
   output logic               oob
);

   // Coordinates are widened to 6 bits so x+3 / y+3 can never wrap back into the board.
   function automatic logic cell_hit(input active_piece_grid_t g, input int row, input int col);
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (g.piece[r][c] &&
                (({1'b0, g.y} + 6'(r)) == 6'(row)) &&
                (({1'b0, g.x} + 6'(c)) == 6'(col)))
               hit = 1'b1;
         end
      end
      return hit;
   endfunction

   for (genvar row = 0; row < BOARD_H; row++) begin : g_row
      for (genvar col = 0; col < BOARD_W; col++) begin : g_col
         assign mask[row][col] = cell_hit(grid, row, col);
      end
   end

   always_comb begin
      oob = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (grid.piece[r][c] &&
                ((({1'b0, grid.y} + 6'(r)) >= 6'(BOARD_H)) ||
                 (({1'b0, grid.x} + 6'(c)) >= 6'(BOARD_W))))
               oob = 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_lock_clear.sv
// Authoritative playfield: merges one locked piece per handshake, then removes full
// rows bottom-up, reporting the per-lock and running cleared-line counts.
module board_lock_clear
   import tetris_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_board,
   input  logic               lock_valid,
   output logic               lock_ready,
   input  active_piece_grid_t active_piece_grid,
   output board_t             board,
   output logic               busy,
   output logic               done,
   output logic [2:0]         lines_cleared,
   output logic [15:0]        lines_total,
   output logic               merge_err
);

   lock_state_t        state;
   lock_state_t        state_next;
   logic [4:0]         row;
   active_piece_grid_t grid_q;
   board_t             mask;
   board_t             shifted;
   logic               oob;
   logic               overlap;
   logic               row_full;
   logic               incoming_full;

   grid_to_board_mask u_mask (
      .grid (grid_q),
      .mask (mask),
      .oob  (oob)
   );

   assign overlap       = |(mask & board);
   assign row_full      = &board[row];
   // The row about to drop into the cleared slot; row 0 always refills with empty cells.
   assign incoming_full = (row != 5'd0) && (&board[row - 5'd1]);

   // Rows at or above the cleared row move down one; rows below it are untouched.
   assign shifted[0] = '0;
   for (genvar k = 1; k < BOARD_H; k++) begin : g_shift
      assign shifted[k] = (5'(k) <= row) ? board[k-1] : board[k];
   end

   assign lock_ready = (state == IDLE) && !clear_board;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // SHIFT already knows whether the row sliding into place is full, so it re-clears
   // in place or moves on itself; the re-scan of the same row is folded into SHIFT.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (lock_valid && lock_ready) state_next = MERGE;
         MERGE: state_next = SCAN;
         SCAN: begin
            if (row_full)
               state_next = SHIFT;
            else if (row == 5'd0)
               state_next = DONE;
         end
         SHIFT: begin
            if (incoming_full)
               state_next = SHIFT;
            else if (row == 5'd0)
               state_next = DONE;
            else
               state_next = SCAN;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear_board)
         state_next = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         row           <= '0;
         grid_q        <= '0;
         board         <= '0;
         lines_cleared <= '0;
         lines_total   <= '0;
         merge_err     <= 1'b0;
      end else begin
         state <= state_next;
         if (clear_board) begin
            row           <= '0;
            board         <= '0;
            lines_cleared <= '0;
            lines_total   <= '0;
            merge_err     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (lock_valid) begin
                     grid_q        <= active_piece_grid;
                     lines_cleared <= '0;
                  end
               end
               MERGE: begin
                  board <= board | mask;
                  row   <= 5'(BOARD_H - 1);
                  if (oob || overlap)
                     merge_err <= 1'b1;
               end
               SCAN: begin
                  if (!row_full && (row != 5'd0))
                     row <= row - 5'd1;
               end
               SHIFT: begin
                  board         <= shifted;
                  lines_cleared <= lines_cleared + 3'd1;
                  if (lines_total != 16'hFFFF)
                     lines_total <= lines_total + 16'd1;
                  if (!incoming_full && (row != 5'd0))
                     row <= row - 5'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_board_lock_clear.sv
// Scoreboard bench for board_lock_clear: directed locks push hand-computed results,
// a monitor checks each done pulse (latency, counts, error flag, board image).
module tb_board_lock_clear;
   import tetris_pkg::*;

   logic               clk;
   logic               reset;
   logic               clear_board;
   logic               lock_valid;
   logic               lock_ready;
   active_piece_grid_t active_piece_grid;
   board_t             board;
   logic               busy;
   logic               done;
   logic [2:0]         lines_cleared;
   logic [15:0]        lines_total;
   logic               merge_err;

   typedef struct {
      int          lat;
      logic [2:0]  lc;
      logic [15:0] lt;
      logic        me;
      board_t      b;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   board_lock_clear dut (
      .clk               (clk),
      .reset             (reset),
      .clear_board       (clear_board),
      .lock_valid        (lock_valid),
      .lock_ready        (lock_ready),
      .active_piece_grid (active_piece_grid),
      .board             (board),
      .busy              (busy),
      .done              (done),
      .lines_cleared     (lines_cleared),
      .lines_total       (lines_total),
      .merge_err         (merge_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic active_piece_grid_t mk(input logic [3:0] r0, input logic [3:0] r1,
                                             input logic [3:0] r2, input logic [3:0] r3,
                                             input logic [4:0] x, input logic [4:0] y);
      active_piece_grid_t g;
      g.piece[0] = r0;
      g.piece[1] = r1;
      g.piece[2] = r2;
      g.piece[3] = r3;
      g.x = x;
      g.y = y;
      return g;
   endfunction

   function automatic board_t rowset(input board_t b, input int r, input logic [9:0] v);
      board_t t;
      t = b;
      t[r] = v;
      return t;
   endfunction

   // Latency counts clock edges from the accept edge (as 1) through the edge raising done.
   initial begin
      bit   counting;
      bit   acc;
      int   edges;
      exp_t e;
      counting = 1'b0;
      edges    = 0;
      forever begin
         @(negedge clk);
         acc = lock_valid && lock_ready && !reset;
         if (clear_board) counting = 1'b0;
         @(posedge clk);
         #1;
         if (reset) begin
            counting = 1'b0;
         end else begin
            if (acc) begin
               counting = 1'b1;
               edges    = 1;
            end else if (counting) begin
               edges++;
            end
            if (done) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("latency", counting ? edges : -1, e.lat);
                  checkOutput("lines_cleared", lines_cleared, e.lc);
                  checkOutput("lines_total", lines_total, e.lt);
                  checkOutput("merge_err", merge_err, e.me);
                  checkOutput("board", board, e.b);
               end
               counting = 1'b0;
            end
         end
      end
   end

   task automatic waitIdle();
      int i;
      for (i = 0; i < 100; i++) begin
         if (!busy) break;
         @(posedge clk);
         #2;
      end
      if (busy) checkOutput("idle_timeout", busy, 0);
   endtask

   task automatic waitReady();
      int i;
      for (i = 0; i < 100; i++) begin
         if (lock_ready) break;
         @(posedge clk);
         #2;
      end
      if (!lock_ready) checkOutput("ready_timeout", lock_ready, 1);
   endtask

   // Issue one lock; the grid is scrambled right after the accept edge.
   task automatic applyStimulus(input active_piece_grid_t g, input int lat, input logic [2:0] lc,
                                input logic [15:0] lt, input logic me, input board_t b);
      exp_t e;
      waitReady();
      e.lat = lat;
      e.lc  = lc;
      e.lt  = lt;
      e.me  = me;
      e.b   = b;
      sb.push_back(e);
      active_piece_grid = g;
      lock_valid = 1'b1;
      @(posedge clk);
      #2;
      lock_valid = 1'b0;
      active_piece_grid = ~g;
      checkOutput("ready_drop", lock_ready, 0);
      waitIdle();
   endtask

   task automatic doClear();
      clear_board = 1'b1;
      @(posedge clk);
      #2;
      clear_board = 1'b0;
      checkOutput("clr_board", board, 0);
      checkOutput("clr_total", lines_total, 0);
      checkOutput("clr_err", merge_err, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      board_t b;
      reset = 1'b1;
      clear_board = 1'b0;
      lock_valid = 1'b0;
      active_piece_grid = '0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;

      checkOutput("rst_board", board, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_lc", lines_cleared, 0);
      checkOutput("rst_lt", lines_total, 0);
      checkOutput("rst_err", merge_err, 0);
      checkOutput("rst_ready", lock_ready, 1);

      // Horizontal I on the bottom row of an empty well
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd19),
                    22, 3'd0, 16'd0, 1'b0, rowset(board_t'(0), 19, 10'h00F));

      // Clear during SCAN alongside a fresh request
      waitReady();
      active_piece_grid = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd0);
      lock_valid = 1'b1;
      @(posedge clk);
      #2;
      lock_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checkOutput("scan_busy", busy, 1);
      clear_board = 1'b1;
      lock_valid  = 1'b1;
      checkOutput("clr_ready_low", lock_ready, 0);
      @(posedge clk);
      #2;
      clear_board = 1'b0;
      lock_valid  = 1'b0;
      checkOutput("abort_board", board, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_lc", lines_cleared, 0);
      repeat (30) @(posedge clk);
      #2;
      checkOutput("abort_not_accepted", busy, 0);

      // Prefill row 19 = 3F0, then complete it with an I piece
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd4, 5'd19),
                    22, 3'd0, 16'd0, 1'b0, rowset(board_t'(0), 19, 10'h0F0));
      applyStimulus(mk(4'b0011, 4'b0000, 4'b0000, 4'b0000, 5'd8, 5'd19),
                    22, 3'd0, 16'd0, 1'b0, rowset(board_t'(0), 19, 10'h3F0));
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd19),
                    23, 3'd1, 16'd1, 1'b0, board_t'(0));

      // Overlap on an occupied cell
      doClear();
      applyStimulus(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd19),
                    22, 3'd0, 16'd0, 1'b0, rowset(board_t'(0), 19, 10'h001));
      applyStimulus(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd19),
                    22, 3'd0, 16'd0, 1'b1, rowset(board_t'(0), 19, 10'h001));

      // Four stacked rows missing col 9, with a marker cell in row 15
      doClear();
      b = rowset(board_t'(0), 15, 10'h001);
      applyStimulus(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd0, 5'd15), 22, 3'd0, 16'd0, 1'b0, b);
      for (int r = 16; r < 20; r++) b = rowset(b, r, 10'h00F);
      applyStimulus(mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 5'd0, 5'd16), 22, 3'd0, 16'd0, 1'b0, b);
      for (int r = 16; r < 20; r++) b = rowset(b, r, 10'h0FF);
      applyStimulus(mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 5'd4, 5'd16), 22, 3'd0, 16'd0, 1'b0, b);
      for (int r = 16; r < 20; r++) b = rowset(b, r, 10'h1FF);
      applyStimulus(mk(4'b0001, 4'b0001, 4'b0001, 4'b0001, 5'd8, 5'd16), 22, 3'd0, 16'd0, 1'b0, b);
      applyStimulus(mk(4'b0001, 4'b0001, 4'b0001, 4'b0001, 5'd9, 5'd16),
                    26, 3'd4, 16'd4, 1'b0, rowset(board_t'(0), 19, 10'h001));

      // Cells past the right wall are dropped, in-bounds ones still land
      b = rowset(rowset(board_t'(0), 19, 10'h001), 0, 10'h300);
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd8, 5'd0), 22, 3'd0, 16'd4, 1'b1, b);

      // Build a nearly full row 19, then reset while clearing it
      b = rowset(b, 19, 10'h01F);
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd1, 5'd19), 22, 3'd0, 16'd4, 1'b1, b);
      b = rowset(b, 19, 10'h1FF);
      applyStimulus(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 5'd5, 5'd19), 22, 3'd0, 16'd4, 1'b1, b);
      waitReady();
      active_piece_grid = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5'd9, 5'd19);
      lock_valid = 1'b1;
      @(posedge clk);
      #2;
      lock_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("shift_busy", busy, 1);
      reset = 1'b1;
      #1;
      checkOutput("arst_board", board, 0);
      checkOutput("arst_busy", busy, 0);
      checkOutput("arst_done", done, 0);
      checkOutput("arst_lc", lines_cleared, 0);
      checkOutput("arst_lt", lines_total, 0);
      checkOutput("arst_err", merge_err, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("post_rst_ready", lock_ready, 1);
      checkOutput("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
